// File: rtl/router_ingress_sched.sv
// Round-robin ingress scheduler: forwards one source's whole packet (header, payload, generated XOR parity) and discards address-3 packets.
// Latency: grant one edge after a request is seen in IDLE; an accepted byte reaches data_out_o on the following edge.
// Backpressure: busy_i freezes data_out_o/pkt_valid_o and deasserts src_ready_o; a packet being discarded ignores busy_i.
module router_ingress_sched #(
    parameter int NUM_SRC    = 2,  // 2..4
    parameter int GAP_CYCLES = 2   // must be at least 1
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [NUM_SRC-1:0]     src_valid_i,
    input  logic [8*NUM_SRC-1:0]   src_data_i,
    output logic [NUM_SRC-1:0]     src_ready_o,
    input  logic                   busy_i,
    output logic                   pkt_valid_o,
    output logic [7:0]             data_out_o,
    output logic [NUM_SRC-1:0]     grant_o,
    output logic                   drop_pkt_o
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PAY, S_PAR, S_DROP, S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IW-1:0]     sel_q, sel_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [7:0]        parity_q, parity_d;
    logic [7:0]        data_q, data_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              drop_q, drop_d;
    logic [GW-1:0]     gap_q, gap_d;

    // Byte and valid of the currently selected source.
    logic              cur_vld;
    logic [7:0]        cur_dat;
    assign cur_vld = src_valid_i[sel_q];
    assign cur_dat = src_data_i[{sel_q, 3'b000} +: 8];

    // Round-robin search: first requester at or after rr_ptr_q, wrapping.
    logic              found;
    logic [IW-1:0]     win;
    logic [IW-1:0]     rr_idx;
    logic [NUM_SRC-1:0] win_oh;
    always_comb begin
        found  = 1'b0;
        win    = '0;
        rr_idx = '0;
        win_oh = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rr_idx = IW'((int'(rr_ptr_q) + k) % NUM_SRC);
            if (!found && src_valid_i[rr_idx]) begin
                found       = 1'b1;
                win         = rr_idx;
                win_oh      = '0;
                win_oh[rr_idx] = 1'b1;
            end
        end
    end

    // Next-state and handshake logic for the packet FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        parity_d    = parity_q;
        data_d      = data_q;
        pkt_valid_d = pkt_valid_q;
        drop_d      = 1'b0;
        gap_d       = gap_q;
        src_ready_o = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d  = win_oh;
                    sel_d    = win;
                    rr_ptr_d = (int'(win) == NUM_SRC - 1) ? '0 : win + 1'b1;
                    state_d  = S_HDR;
                end
            end
            S_HDR: begin
                if (!busy_i) begin
                    src_ready_o = grant_q;
                    if (cur_vld) begin
                        cnt_d    = cur_dat[7:2];
                        parity_d = cur_dat;
                        if (cur_dat[1:0] == 2'b11) begin
                            // Zero-length illegal packet is already fully consumed.
                            if (cur_dat[7:2] == 6'd0) begin
                                drop_d  = 1'b1;
                                grant_d = '0;
                                gap_d   = '0;
                                state_d = S_GAP;
                            end else begin
                                state_d = S_DROP;
                            end
                        end else begin
                            data_d      = cur_dat;
                            pkt_valid_d = 1'b1;
                            state_d     = S_PAY;
                        end
                    end
                end
            end
            S_PAY: begin
                // cnt_q == 0 means the last byte is on the output; parity follows once it is taken.
                if (!busy_i) begin
                    if (cnt_q == 6'd0) begin
                        data_d      = parity_q;
                        pkt_valid_d = 1'b0;
                        state_d     = S_PAR;
                    end else begin
                        src_ready_o = grant_q;
                        if (cur_vld) begin
                            data_d   = cur_dat;
                            parity_d = parity_q ^ cur_dat;
                            cnt_d    = cnt_q - 6'd1;
                        end
                    end
                end
            end
            S_PAR: begin
                if (!busy_i) begin
                    data_d  = 8'h00;
                    grant_d = '0;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_DROP: begin
                src_ready_o = grant_q;
                if (cur_vld) begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        drop_d  = 1'b1;
                        grant_d = '0;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            parity_q    <= '0;
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            parity_q    <= parity_d;
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            drop_q      <= drop_d;
            gap_q       <= gap_d;
        end
    end

    assign pkt_valid_o = pkt_valid_q;
    assign data_out_o  = data_q;
    assign grant_o     = grant_q;
    assign drop_pkt_o  = drop_q;

endmodule
